led_ctrl: RTL and testbench
===========================

# led_ctrl

Sequencing controller for the LED-cube datapath. It converts board inputs into the datapath's mode strobes: a go button, a pause button and an off switch. The strobes step the cube through countdown animation, position selection, colour selection (with zero-colour rejection) and the free-running animation. It sits between the board I/O and the datapath, consuming the datapath's `cda_done` and `rcm` status.

## Interface
- `CDA_TIMEOUT`, default 250000000: maximum cycles spent in countdown before forcing progress (5 s at 50 MHz).
- `clk`  in  1  system clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `go`  in  1  go button, active-high level, held while pressed.
- `pause_btn`  in  1  pause button, active-high level.
- `off_sw`  in  1  off switch, active-high level.
- `cda_done`  in  1  countdown-finished status from the datapath.
- `rcm`  in  1  reselect-colour flag from the datapath (1 = colour 0 chosen).
- `load`  out  1  one-cycle commit strobe.
- `cda`  out  1  countdown animation enable.
- `pos`  out  1  position-select mode.
- `cho_c`  out  1  colour-select mode.
- `ans`  out  1  animation-start/run.
- `pause`  out  1  animation pause.
- `off`  out  1  display off.
- `state`  out  4  current state code, for HEX display.
- `placed`  out  9  count of committed LEDs, saturating.

## Operation
- Edge detect: `go_q` and `pause_q` registered copies. `go_rise = go & ~go_q`, `pause_rise = pause_btn & ~pause_q`. Both `_q` registers reset to 1, so a button held through reset release does not fire.
- State codes: IDLE 0, CDA_RUN 1, POS_SEL 2, COL_SEL 3, COL_CHK 4, ANIM 5, PAUSED 6, OFF 7.
- Moore outputs are decoded from the state register. Only the listed outputs are 1; all others are 0.
  - IDLE: none.
  - CDA_RUN: `cda`.
  - POS_SEL: `pos`.
  - COL_SEL: `cho_c`.
  - COL_CHK: `load`.
  - ANIM: `ans`.
  - PAUSED: `ans` and `pause`.
  - OFF: `off`.
- Transitions, in priority order:
  - `off_sw`=1 in any state goes to OFF, overriding all else.
  - OFF returns to IDLE when `off_sw`=0.
  - IDLE goes to CDA_RUN on `go_rise`.
  - CDA_RUN goes to POS_SEL on `cda_done`=1 or when the timer equals CDA_TIMEOUT-1, whichever comes first.
  - POS_SEL goes to COL_SEL on `go_rise`.
  - COL_SEL goes to COL_CHK on `go_rise`.
  - COL_CHK lasts exactly one cycle. If `rcm`=1 it returns to COL_SEL and `placed` is unchanged. Otherwise it goes to ANIM and `placed` increments, saturating at 511.
  - ANIM goes to PAUSED on `pause_rise`, else to POS_SEL on `go_rise`. `pause_rise` wins when both occur.
  - PAUSED goes to ANIM on `pause_rise`. `go_rise` is ignored in PAUSED.
- Timer: width is clog2(CDA_TIMEOUT+1). It is cleared on every entry to CDA_RUN, increments each cycle in CDA_RUN, and holds 0 in all other states.
- `placed` is cleared on reset and on entry to OFF.

## Timing
- Reset: at the first clk edge with `resetn`=0, state becomes IDLE and the timer and `placed` become 0. All strobes are 0 and `state`=0 from then on.
- Reset mid-operation has the same effect regardless of state. No partial commit: `load` is 0 in the reset cycle.
- Input latency: `go` rising before edge N (low before edge N-1) means `go_rise` is true at edge N and the state changes at edge N. Outputs follow in the same cycle as the state.
- Countdown timeout: CDA_RUN lasts at most CDA_TIMEOUT cycles.
- `cda_done` is sampled every cycle in CDA_RUN; `cda_done` asserted in other states is ignored.
- `rcm` is sampled only at the COL_CHK edge. The datapath updates `rcm` while `cho_c`=1, so COL_SEL always lasts at least one cycle before COL_CHK.
- `load` is high for exactly one cycle per COL_CHK visit.

## Structure
- Package `led_ctrl_pkg` holds the state code constants and the state width (4) and `placed` width (9).
- Sub-module `edge_det` (registered rise detector with reset value 1) is instantiated twice, for `go` and `pause_btn`.
- FSM, timer and `placed` counter live in `led_ctrl`.

## Test plan
All scenarios use CDA_TIMEOUT=8.
- Reset with `go` held high, then release reset: state stays 0, no strobes. Drop `go` and raise it again: state becomes 1 at the next edge and `cda`=1.
- CDA_RUN with `cda_done` held at 0: exactly 8 cycles with `cda`=1, then state 2 and `pos`=1.
- CDA_RUN with `cda_done` pulsed on cycle 3: state 2 on the following edge and the timer reads 0.
- POS_SEL, go, COL_SEL, go, then COL_CHK with `rcm`=1: one `load` pulse, back to state 3, `placed` stays 0. Repeat with `rcm`=0: state 5, `placed`=1.
- In ANIM, raise `go` and `pause_btn` in the same cycle: state 6 with `pause`=1 and `ans`=1. A second `pause_rise` returns to state 5.
- Raise `off_sw` during COL_SEL with `placed`=3: state 7, `off`=1, `placed`=0. Drop `off_sw`: state 0.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// rtl/led_ctrl_pkg.sv - state codes and widths shared by the LED-cube sequencer
package led_ctrl_pkg;

  localparam int STATE_W  = 4;
  localparam int PLACED_W = 9;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 4'd0,
    ST_CDA_RUN = 4'd1,
    ST_POS_SEL = 4'd2,
    ST_COL_SEL = 4'd3,
    ST_COL_CHK = 4'd4,
    ST_ANIM    = 4'd5,
    ST_PAUSED  = 4'd6,
    ST_OFF     = 4'd7
  } state_t;

endpackage

// File: rtl/led_ctrl_edge_det.sv
// rtl/led_ctrl_edge_det.sv - registered rising-edge detector for a board button
// The history register resets to 1 so a button held through reset release never fires.
module edge_det (
  input  logic clk,
  input  logic resetn,
  input  logic i_d,
  output logic o_rise
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (!resetn) r_q <= 1'b1;
    else         r_q <= i_d;
  end

  assign o_rise = i_d & ~r_q;

endmodule

// File: rtl/led_ctrl.sv
// rtl/led_ctrl.sv - LED-cube sequencing FSM with countdown timer and placed-LED counter
// Turns go/pause/off board inputs into datapath mode strobes.
module led_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int CDA_TIMEOUT = 250000000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                go,
  input  logic                pause_btn,
  input  logic                off_sw,
  input  logic                cda_done,
  input  logic                rcm,
  output logic                load,
  output logic                cda,
  output logic                pos,
  output logic                cho_c,
  output logic                ans,
  output logic                pause,
  output logic                off,
  output logic [STATE_W-1:0]  state,
  output logic [PLACED_W-1:0] placed
);

  localparam int TIMER_W = $clog2(CDA_TIMEOUT + 1);
  localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(CDA_TIMEOUT - 1);
  localparam logic [PLACED_W-1:0] PLACED_MAX = '1;

  logic               w_go_rise;
  logic               w_pause_rise;
  state_t             r_state;
  state_t             w_next;
  logic [TIMER_W-1:0] r_timer;
  logic [PLACED_W-1:0] r_placed;

  edge_det u_go_edge (
    .clk    (clk),
    .resetn (resetn),
    .i_d    (go),
    .o_rise (w_go_rise)
  );

  edge_det u_pause_edge (
    .clk    (clk),
    .resetn (resetn),
    .i_d    (pause_btn),
    .o_rise (w_pause_rise)
  );

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    load   = 1'b0;
    cda    = 1'b0;
    pos    = 1'b0;
    cho_c  = 1'b0;
    ans    = 1'b0;
    pause  = 1'b0;
    off    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_go_rise) w_next = ST_CDA_RUN;
      end
      ST_CDA_RUN: begin
        cda = 1'b1;
        if (cda_done || r_timer == TIMER_LAST) w_next = ST_POS_SEL;
      end
      ST_POS_SEL: begin
        pos = 1'b1;
        if (w_go_rise) w_next = ST_COL_SEL;
      end
      ST_COL_SEL: begin
        cho_c = 1'b1;
        if (w_go_rise) w_next = ST_COL_CHK;
      end
      ST_COL_CHK: begin
        load   = 1'b1;
        w_next = rcm ? ST_COL_SEL : ST_ANIM;
      end
      ST_ANIM: begin
        ans = 1'b1;
        // pause has priority over go when both rise together
        if (w_pause_rise)   w_next = ST_PAUSED;
        else if (w_go_rise) w_next = ST_POS_SEL;
      end
      ST_PAUSED: begin
        ans   = 1'b1;
        pause = 1'b1;
        if (w_pause_rise) w_next = ST_ANIM;
      end
      ST_OFF: begin
        off    = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    if (off_sw) w_next = ST_OFF;
  end

  // Timer only counts while remaining in CDA_RUN, so every entry starts from zero.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_timer  <= '0;
      r_placed <= '0;
    end else begin
      if (r_state == ST_CDA_RUN && w_next == ST_CDA_RUN) r_timer <= r_timer + 1'b1;
      else                                               r_timer <= '0;
      if (w_next == ST_OFF)
        r_placed <= '0;
      else if (r_state == ST_COL_CHK && w_next == ST_ANIM && r_placed != PLACED_MAX)
        r_placed <= r_placed + 1'b1;
    end
  end

  assign state  = r_state;
  assign placed = r_placed;

endmodule

// File: tb/tb_led_ctrl.sv
// tb/tb_led_ctrl.sv - bench for led_ctrl: behavioural model, per-cycle compare, directed and random stimulus
module tb_led_ctrl;

  localparam int T = 8;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       go = 1'b1, pause_btn = 1'b0, off_sw = 1'b0, cda_done = 1'b0, rcm = 1'b0;
  logic       load, cda, pos, cho_c, ans, pause, off;
  logic [3:0] state;
  logic [8:0] placed;

  int compared = 0;
  int mismatched = 0;
  bit chk_en = 1'b0;

  // model: state code, button history, countdown cycles spent, placed count
  int m_state = 0, m_cnt = 0, m_placed = 0;
  bit m_goq = 1'b1, m_pq = 1'b1;

  led_ctrl #(.CDA_TIMEOUT(T)) dut (
    .clk(clk), .resetn(resetn), .go(go), .pause_btn(pause_btn), .off_sw(off_sw),
    .cda_done(cda_done), .rcm(rcm), .load(load), .cda(cda), .pos(pos),
    .cho_c(cho_c), .ans(ans), .pause(pause), .off(off), .state(state), .placed(placed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // expected strobes {load,cda,pos,cho_c,ans,pause,off} for each state code
  function automatic int exp_outs(input int s);
    case (s)
      1: return 7'b0100000;
      2: return 7'b0010000;
      3: return 7'b0001000;
      4: return 7'b1000000;
      5: return 7'b0000100;
      6: return 7'b0000110;
      7: return 7'b0000001;
      default: return 7'b0000000;
    endcase
  endfunction

  always @(posedge clk) begin
    bit gr, pr;
    int ns;
    if (!resetn) begin
      m_state = 0; m_cnt = 0; m_placed = 0; m_goq = 1'b1; m_pq = 1'b1;
    end else begin
      gr = go && !m_goq;
      pr = pause_btn && !m_pq;
      m_goq = go;
      m_pq = pause_btn;
      ns = m_state;
      if (off_sw) ns = 7;
      else case (m_state)
        0: if (gr) ns = 1;
        1: if (cda_done || m_cnt + 1 >= T) ns = 2;
        2: if (gr) ns = 3;
        3: if (gr) ns = 4;
        4: ns = rcm ? 3 : 5;
        5: if (pr) ns = 6; else if (gr) ns = 2;
        6: if (pr) ns = 5;
        default: ns = 0;
      endcase
      if (ns == 7) m_placed = 0;
      else if (m_state == 4 && ns == 5 && m_placed < 511) m_placed = m_placed + 1;
      m_cnt = (m_state == 1 && ns == 1) ? m_cnt + 1 : 0;
      m_state = ns;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_state", int'(state), m_state);
      chk("model_strobes", int'({load, cda, pos, cho_c, ans, pause, off}), exp_outs(m_state));
      chk("model_placed", int'(placed), m_placed);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic go_pulse();
    go = 1'b1; step();
    go = 1'b0; step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // reset with go held; history regs at 1 must swallow the held press
    step(); step();
    chk_en = 1'b1;
    chk("reset_state", int'(state), 0);
    resetn = 1'b1;
    step(); step(); step();
    chk("held_go_state", int'(state), 0);
    chk("held_go_cda", int'(cda), 0);
    go = 1'b0; step();
    go = 1'b1; step();
    chk("go_rise_state", int'(state), 1);
    chk("go_rise_cda", int'(cda), 1);
    go = 1'b0;

    // timeout: 8 cycles in countdown
    n = 1;
    while (state == 4'd1 && n < 40) begin step(); if (state == 4'd1) n++; end
    chk("cda_cycles", n, 8);
    chk("timeout_state", int'(state), 2);
    chk("timeout_pos", int'(pos), 1);

    // back to IDLE via off, then countdown cut short by cda_done on cycle 3
    off_sw = 1'b1; step();
    off_sw = 1'b0; step();
    chk("off_to_idle", int'(state), 0);
    go = 1'b1; step(); go = 1'b0;
    step(); step();
    chk("cda_cycle3_state", int'(state), 1);
    cda_done = 1'b1; step(); cda_done = 1'b0;
    chk("cda_done_state", int'(state), 2);
    chk("cda_done_timer", int'(dut.r_timer), 0);

    // colour reject then accept
    go_pulse();
    chk("col_sel_state", int'(state), 3);
    rcm = 1'b1;
    go = 1'b1; step();
    chk("chk_load", int'(load), 1);
    go = 1'b0; step();
    chk("reject_state", int'(state), 3);
    chk("reject_load", int'(load), 0);
    chk("reject_placed", int'(placed), 0);
    rcm = 1'b0;
    go = 1'b1; step();
    go = 1'b0; step();
    chk("accept_state", int'(state), 5);
    chk("accept_placed", int'(placed), 1);

    // go and pause together in ANIM: pause wins
    go = 1'b1; pause_btn = 1'b1; step();
    chk("pause_state", int'(state), 6);
    chk("pause_strobes", int'({ans, pause}), 3);
    go = 1'b0; pause_btn = 1'b0; step();
    go = 1'b1; step(); go = 1'b0; step();
    chk("paused_ignores_go", int'(state), 6);
    pause_btn = 1'b1; step(); pause_btn = 1'b0; step();
    chk("unpause_state", int'(state), 5);

    // two more placements, then off during COL_SEL
    for (int i = 0; i < 2; i++) begin
      go_pulse(); go_pulse();
      go = 1'b1; step(); go = 1'b0; step();
    end
    go_pulse(); go_pulse();
    chk("pre_off_state", int'(state), 3);
    chk("pre_off_placed", int'(placed), 3);
    off_sw = 1'b1; step();
    chk("off_state", int'(state), 7);
    chk("off_strobe", int'(off), 1);
    chk("off_placed", int'(placed), 0);
    off_sw = 1'b0; step();
    chk("off_release", int'(state), 0);

    // saturation of placed at 511
    go = 1'b1; step(); go = 1'b0;
    cda_done = 1'b1; step(); cda_done = 1'b0;
    for (int i = 0; i < 515; i++) begin
      go_pulse();
      go = 1'b1; step(); go = 1'b0; step();
      go_pulse();
    end
    chk("sat_placed", int'(placed), 511);

    // reset during COL_CHK: no commit
    go_pulse();
    go = 1'b1; step(); go = 1'b0;
    chk("pre_reset_load", int'(load), 1);
    resetn = 1'b0; step();
    chk("mid_reset_state", int'(state), 0);
    chk("mid_reset_load", int'(load), 0);
    chk("mid_reset_placed", int'(placed), 0);
    resetn = 1'b1;

    // random phase, checked cycle by cycle against the model
    for (int i = 0; i < 4000; i++) begin
      go        = ($urandom_range(0, 2) == 0);
      pause_btn = ($urandom_range(0, 5) == 0);
      cda_done  = ($urandom_range(0, 9) == 0);
      rcm       = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 59) == 0) off_sw = ~off_sw;
      resetn    = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
